mod_exp_ctrl: RTL
=================

# mod_exp_ctrl

Upstream sequencer for the modular-exponentiation core. Accepts base, modulus and exponent as a stream of WIDTH-bit words over a valid/ready handshake. Launches the core with a one-cycle start pulse wired to the core's synchronous `reset`, waits for its `finish` and returns the 2·WIDTH-bit result as two words on a valid/ready output stream. Sits between the SoC bus adapter and the exponentiation core.

## Interface
- WIDTH, 32: word width; every operand and the result are 2·WIDTH bits, i.e. two words.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  operand word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted on a cycle where in_valid && in_ready.
- out_data  out  WIDTH  result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in every state except LOAD.
- err  out  1  zero-modulus flag (see Configuration).
- exp_base, exp_modulo, exp_exponent  out  2·WIDTH each  operands to the core.
- exp_start  out  1  one-cycle pulse to the core's `reset`.
- exp_finish  in  1  core done.
- exp_result  in  2·WIDTH  core result.

## Operation
- Input word order: base lo, base hi, modulo lo, modulo hi, exponent lo, exponent hi. A 3-bit word counter runs 0..5.
- Output word order: result lo, then result hi.
- States: LOAD, START, WAIT, UNLOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word is written into its operand slot and the counter increments.
  - On acceptance of word 5, the counter clears and the state goes to START.
- START:
  - exp_start=1 for exactly this cycle, then go to WAIT.
  - The armed flag clears.
- WAIT:
  - The first WAIT cycle sets armed and ignores exp_finish, because a stale finish from the previous run may still be visible.
  - When armed && exp_finish: capture exp_result into the output register, clear the output word index, go to UNLOAD.
- UNLOAD:
  - out_valid=1 and out_data = the selected half of the captured result.
  - On out_valid && out_ready, advance the index.
  - After the hi word is accepted, go to LOAD.
- exp_base/modulo/exponent are driven from the operand registers. They are stable from START until the next LOAD acceptance.
- in_ready=0 outside LOAD. out_valid=0 outside UNLOAD. A new job never overlaps an unload.
- Words presented while reset_n=0 are not captured.

## Timing
- Reset values:
  - state=LOAD; counters=0; armed=0.
  - Operand and result registers=0.
  - in_ready=1 (combinational state decode), out_valid=0, exp_start=0, busy=0, err=0.
- Last input accept at edge T: START in T..T+1, first WAIT cycle at T+1..T+2.
- exp_finish high in cycle C (C ≥ second WAIT cycle): out_valid rises in cycle C+1.
- Controller overhead is 3 cycles plus core latency plus 2 output handshakes.
- Backpressure: out_data and out_valid are held unchanged while out_valid && !out_ready.
- Input stalls: in_valid low in LOAD leaves the counter and registers unchanged. Arbitrary gaps are allowed.
- Reset mid-operation: return to the reset values immediately, and any partially loaded job is discarded. The core keeps its own state, but the next START re-initialises it.

## Configuration
- MOD_EXP_CTRL_ZERO_MOD_CHECK_EN defined:
  - In START, if the modulo is 0, exp_start is not pulsed.
  - The result register is loaded with 0, err is set, and the state goes straight to UNLOAD.
  - err clears on the next word-0 acceptance in LOAD.
- Macro undefined:
  - err is tied to 0.
  - A zero modulus is launched normally and the result is undefined.

## Structure
- Shared package rsa_pkg holds:
  - the state enum LOAD/START/WAIT/UNLOAD;
  - the constants OP_WORDS=6 and RES_WORDS=2;
  - the operand slot indices.
- No sub-module: the operand slots and output mux are small enough to stay inline.
- The exponentiation core is instantiated beside this block at the top level, not inside it.

## Test plan
- Job 1:
  - Stimulus: base=4, modulo=497, exponent=13, words streamed back-to-back, out_ready=1.
  - Response: one exp_start pulse, then out_data 445, then 0; busy low after the hi word.
- Bubbles and backpressure:
  - Stimulus: same job with in_valid toggling every other cycle and out_ready low for 5 cycles.
  - Response: the same result, and out_data stable throughout the stall.
- Exponent 0:
  - Stimulus: base=7, modulo=11, exponent=0.
  - Response: result words 1, 0.
- Back-to-back jobs:
  - Stimulus: job 1, then base=2, modulo=1000, exponent=10.
  - Response: second result 24, 0, and the stale finish is not taken as completion.
- Reset mid-job:
  - Stimulus: assert reset_n=0 after 3 input words, then send a full job 1.
  - Response: result 445, and no leftover words are used.
- Zero modulus:
  - Stimulus: modulo=0 with the macro defined.
  - Response: no exp_start, err=1, result 0, 0.
  - Without the macro, err stays 0.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the modular-exponentiation controller.
// Holds the controller state enum, word counts and operand slot indices.
package rsa_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_e;

  localparam int OP_WORDS  = 6;
  localparam int RES_WORDS = 2;

  localparam int SLOT_BASE_LO = 0;
  localparam int SLOT_BASE_HI = 1;
  localparam int SLOT_MOD_LO  = 2;
  localparam int SLOT_MOD_HI  = 3;
  localparam int SLOT_EXP_LO  = 4;
  localparam int SLOT_EXP_HI  = 5;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Word-stream front end for the exponentiation core: load 6 operand words, launch, unload 2 result words.
// Optional zero-modulus trap enabled by MOD_EXP_CTRL_ZERO_MOD_CHECK_EN.
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err,
  output logic [2*WIDTH-1:0] exp_base,
  output logic [2*WIDTH-1:0] exp_modulo,
  output logic [2*WIDTH-1:0] exp_exponent,
  output logic               exp_start,
  input  logic               exp_finish,
  input  logic [2*WIDTH-1:0] exp_result
);

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       idx_q, idx_d;
  logic       armed_q, armed_d;
  logic [OP_WORDS-1:0][WIDTH-1:0]  ops_q, ops_d;
  logic [RES_WORDS-1:0][WIDTH-1:0] res_q, res_d;
`ifdef MOD_EXP_CTRL_ZERO_MOD_CHECK_EN
  logic err_q, err_d;
  logic mod_zero;
  assign mod_zero = (ops_q[SLOT_MOD_LO] == '0) && (ops_q[SLOT_MOD_HI] == '0);
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  assign exp_base     = {ops_q[SLOT_BASE_HI], ops_q[SLOT_BASE_LO]};
  assign exp_modulo   = {ops_q[SLOT_MOD_HI],  ops_q[SLOT_MOD_LO]};
  assign exp_exponent = {ops_q[SLOT_EXP_HI],  ops_q[SLOT_EXP_LO]};
  assign out_data     = res_q[idx_q];
  assign busy         = (state_q != LOAD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    armed_d   = armed_q;
    ops_d     = ops_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    exp_start = 1'b0;
`ifdef MOD_EXP_CTRL_ZERO_MOD_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ops_d[cnt_q] = in_data;
`ifdef MOD_EXP_CTRL_ZERO_MOD_CHECK_EN
          if (cnt_q == 3'd0) err_d = 1'b0;
`endif
          if (cnt_q == 3'(OP_WORDS - 1)) begin
            cnt_d   = 3'd0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      START: begin
        armed_d = 1'b0;
`ifdef MOD_EXP_CTRL_ZERO_MOD_CHECK_EN
        if (mod_zero) begin
          res_d   = '0;
          err_d   = 1'b1;
          idx_d   = 1'b0;
          state_d = UNLOAD;
        end else begin
          exp_start = 1'b1;
          state_d   = WAIT;
        end
`else
        exp_start = 1'b1;
        state_d   = WAIT;
`endif
      end
      WAIT: begin
        // First WAIT cycle may still see the previous run's finish
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (exp_finish) begin
          res_d   = exp_result;
          idx_d   = 1'b0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == 1'b1) begin
            idx_d   = 1'b0;
            state_d = LOAD;
          end else begin
            idx_d = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      idx_q   <= 1'b0;
      armed_q <= 1'b0;
      ops_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
    end
  end

`ifdef MOD_EXP_CTRL_ZERO_MOD_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

endmodule
